// File: rtl/ifu_if.sv
// Instruction-memory read port between the IFU (master) and the instruction memory (slave).
// Handshake: the master raises imem_req with imem_addr and holds both stable until the cycle
// in which the slave returns imem_ack=1; imem_rdata is valid only in that cycle.
interface ifu_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifu.sv
// Multi-cycle instruction fetch unit: fetches into IR, holds it until the controller commits.
// Optional misaligned-target trap enabled by defining IFU_ALIGN_CHECK_EN.
module ifu (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         PCWr,
  input  logic [1:0]   NPCSel,
  input  logic [31:0]  reg_target,
  ifu_if.master        imem,
  output logic [31:0]  instr,
  output logic [5:0]   opcode,
  output logic [5:0]   funct,
  output logic [31:0]  pc,
  output logic [31:0]  pc_plus4,
  output logic         instr_valid,
  output logic         fetch_err,
  output logic [1:0]   dbg_state
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    FETCH      = 2'd1,
    HOLD       = 2'd2
`ifdef IFU_ALIGN_CHECK_EN
    ,ERR       = 2'd3
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic [31:0] npc_raw;
  logic [31:0] npc;
  logic [31:0] br_off;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  always_comb begin
    npc_raw = pc_plus4;
    case (NPCSel)
      2'd0:    npc_raw = pc_plus4;
      2'd1:    npc_raw = pc_plus4 + br_off;
      2'd2:    npc_raw = {pc_plus4[31:28], ir_q[25:0], 2'b00};
      default: npc_raw = reg_target;
    endcase
  end

`ifdef IFU_ALIGN_CHECK_EN
  assign npc = npc_raw;
`else
  // Without the trap, a misaligned target is silently rounded down to a word boundary.
  assign npc = npc_raw & 32'hFFFF_FFFC;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = req_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      RESET_WAIT: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          state_d = HOLD;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (PCWr) begin
          valid_d = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
          if (npc[1:0] != 2'b00) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            pc_d    = npc;
            req_d   = 1'b1;
            state_d = FETCH;
          end
`else
          pc_d    = npc;
          req_d   = 1'b1;
          state_d = FETCH;
`endif
        end
      end
      default: begin
        // ERR is sticky until reset; outputs already hold their trap values.
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_WAIT;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = ir_q;
  assign opcode         = ir_q[31:26];
  assign funct          = ir_q[5:0];
  assign pc             = pc_q;
  assign instr_valid    = valid_q;
  assign fetch_err      = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a small memory driver, hand-computed expectations, one summary line.
module tb_ifu;

  logic        clk;
  logic        rst_n;
  logic        PCWr;
  logic [1:0]  NPCSel;
  logic [31:0] reg_target;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  int n_tests;
  int n_fail;

  ifu_if imem_bus ();

  ifu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCWr        (PCWr),
    .NPCSel      (NPCSel),
    .reg_target  (reg_target),
    .imem        (imem_bus),
    .instr       (instr),
    .opcode      (opcode),
    .funct       (funct),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory driver: serve the FETCH now becoming visible, after `delay` wait cycles
  // during which PCWr is pulsed and must be ignored.
  task automatic do_fetch(input string tag, input logic [31:0] exp_addr,
                          input logic [31:0] data, input int delay);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check_eq({tag, "_wait_req"},   {31'b0, imem_bus.imem_req}, 32'd1);
      check_eq({tag, "_wait_addr"},  imem_bus.imem_addr, exp_addr);
      check_eq({tag, "_wait_valid"}, {31'b0, instr_valid}, 32'd0);
      imem_bus.imem_ack = 1'b0;
      PCWr = 1'b1;
    end
    @(negedge clk);
    check_eq({tag, "_req"},  {31'b0, imem_bus.imem_req}, 32'd1);
    check_eq({tag, "_addr"}, imem_bus.imem_addr, exp_addr);
    PCWr = 1'b0;
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = data;
    @(negedge clk);
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    check_eq({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    check_eq({tag, "_instr"}, instr, data);
    check_eq({tag, "_pc"},    pc, exp_addr);
    check_eq({tag, "_hold_req"}, {31'b0, imem_bus.imem_req}, 32'd0);
  endtask

  task automatic commit(input logic [1:0] sel, input logic [31:0] target);
    NPCSel     = sel;
    reg_target = target;
    PCWr       = 1'b1;
    @(posedge clk);
    #1;
    PCWr = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    PCWr = 1'b0;
    NPCSel = 2'd0;
    reg_target = 32'h0;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;

    repeat (2) @(negedge clk);
    check_eq("rst_pc",    pc, 32'h0000_3000);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("rst_req",   {31'b0, imem_bus.imem_req}, 32'd0);
    check_eq("rst_err",   {31'b0, fetch_err}, 32'd0);
    rst_n = 1'b1;

    // zero-wait first fetch (lui)
    do_fetch("f0", 32'h0000_3000, 32'h3C01_1234, 0);
    check_eq("f0_opcode", {26'b0, opcode}, 32'h0F);
    check_eq("f0_funct",  {26'b0, funct}, 32'h34);
    check_eq("f0_pc4",    pc_plus4, 32'h0000_3004);

    // delayed ack, PCWr pulses ignored while fetching
    commit(2'd0, 32'h0);
    do_fetch("f1", 32'h0000_3004, 32'h0000_0020, 3);
    check_eq("f1_funct", {26'b0, funct}, 32'h20);

    commit(2'd0, 32'h0);
    do_fetch("f2", 32'h0000_3008, 32'h1000_FFFF, 0);
    // beq offset -1: target equals current pc
    commit(2'd1, 32'h0);
    do_fetch("beq_m1", 32'h0000_3008, 32'h1000_0001, 0);
    commit(2'd1, 32'h0);
    do_fetch("beq_p1", 32'h0000_3010, 32'h0800_0C40, 0);
    check_eq("j_pc4_before", pc_plus4, 32'h0000_3014);
    commit(2'd2, 32'h0);
    do_fetch("j", 32'h0000_3100, 32'h03E0_0008, 0);

    // reset while a fetch is outstanding
    commit(2'd0, 32'h0);
    @(negedge clk);
    check_eq("mid_req", {31'b0, imem_bus.imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
    check_eq("mid_rst_pc",  pc, 32'h0000_3000);
    @(negedge clk);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'hBAD0_BAD0;
    rst_n = 1'b1;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    check_eq("stale_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("stale_instr", instr, 32'h0);
    check_eq("stale_req",   {31'b0, imem_bus.imem_req}, 32'd1);
    check_eq("stale_addr",  imem_bus.imem_addr, 32'h0000_3000);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'h0000_0000;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    check_eq("post_rst_valid", {31'b0, instr_valid}, 32'd1);

    // jr to the top word, then PC+4 wraps to zero
    commit(2'd3, 32'hFFFF_FFFC);
    do_fetch("top", 32'hFFFF_FFFC, 32'h0000_0000, 0);
    check_eq("wrap_pc4", pc_plus4, 32'h0000_0000);
    commit(2'd0, 32'h0);
    do_fetch("wrap", 32'h0000_0000, 32'h0000_0000, 1);

    // misaligned register target
    commit(2'd3, 32'h0000_3006);
`ifdef IFU_ALIGN_CHECK_EN
    @(negedge clk);
    check_eq("mis_err",   {31'b0, fetch_err}, 32'd1);
    check_eq("mis_pc",    pc, 32'h0000_0000);
    check_eq("mis_req",   {31'b0, imem_bus.imem_req}, 32'd0);
    check_eq("mis_valid", {31'b0, instr_valid}, 32'd0);
    commit(2'd0, 32'h0);
    @(negedge clk);
    check_eq("mis_sticky", {31'b0, fetch_err}, 32'd1);
`else
    do_fetch("mis", 32'h0000_3004, 32'h0000_0000, 0);
    check_eq("mis_err", {31'b0, fetch_err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
